// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 16-bit instruction
// words and writes them sequentially into instruction memory from address 0.
// Image format: 16-bit LE word count N (1..DEPTH), then N LE words.
module imem_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [15:0]       w_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  lo_byte;
  logic [15:0] len_full;
  logic        xfer;

  // Byte acceptance depends on state only, never on in_valid.
  assign in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA_LO) || (state == DATA_HI);
  assign xfer     = in_valid && in_ready;
  assign len_full = {in_data, len_lo};

  // Session FSM with registered outputs; abort outranks any byte transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len_lo    <= '0;
      len       <= '0;
      lo_byte   <= '0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      core_hold <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      word_cnt  <= '0;
    end else begin
      w_en <= 1'b0;
      if (abort && in_ready) begin
        state     <= IDLE;
        error     <= 1'b1;
        core_hold <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= LEN_LO;
              done      <= 1'b0;
              error     <= 1'b0;
              word_cnt  <= '0;
              core_hold <= 1'b1;
              busy      <= 1'b1;
            end
          end
          LEN_LO: begin
            if (xfer) begin
              len_lo <= in_data;
              state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (xfer) begin
              len <= len_full;
              if ((len_full == 16'd0) || (32'(len_full) > DEPTH)) begin
                state     <= IDLE;
                error     <= 1'b1;
                core_hold <= 1'b0;
                busy      <= 1'b0;
              end else begin
                state <= DATA_LO;
              end
            end
          end
          DATA_LO: begin
            if (xfer) begin
              lo_byte <= in_data;
              state   <= DATA_HI;
            end
          end
          DATA_HI: begin
            if (xfer) begin
              w_en     <= 1'b1;
              w_addr   <= word_cnt;
              w_data   <= {in_data, lo_byte};
              word_cnt <= word_cnt + ADDR_W'(1);
              if ((32'(word_cnt) + 32'd1) == 32'(len)) state <= FINISH;
              else                                     state <= DATA_LO;
            end
          end
          FINISH: begin
            state     <= IDLE;
            done      <= 1'b1;
            core_hold <= 1'b0;
            busy      <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and randomized image loads checked
// against an expected memory image kept as a plain array.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset, start, abort, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, w_en, core_hold, busy, done, error;
  logic [ADDR_W-1:0] w_addr, word_cnt;
  logic [15:0]       w_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] img [0:DEPTH-1];
  int          obs_addr [$];
  int          obs_data [$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .core_hold(core_hold),
    .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen by memory.
  always @(negedge clk) begin
    if (w_en) begin
      obs_addr.push_back(int'(w_addr));
      obs_data.push_back(int'(w_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte (optionally after random idle cycles) until accepted.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Start pulse with a junk byte offered alongside, which must not be taken.
  task automatic pulse_start();
    obs_addr.delete();
    obs_data.delete();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hold", 32'(core_hold), 32'd1);
  endtask

  // Full session: length, n words from img, then timing and content checks.
  task automatic run_load(input int n, input bit stall, input string tag);
    int bad = 0;
    pulse_start();
    send_byte(8'(n), stall);
    send_byte(8'(n >> 8), stall);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][7:0], stall);
      send_byte(img[i][15:8], stall);
    end
    chk({tag, "_final_wen"}, 32'(w_en), 32'd1);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_wen_low"}, 32'(w_en), 32'd0);
    chk({tag, "_hold"}, 32'(core_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(n));
    chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      if (obs_addr[i] != i || obs_data[i] != int'(img[i])) bad++;
    end
    chk({tag, "_content_errs"}, 32'(bad), 32'd0);
  endtask

  task automatic bad_len(input int n, input string tag);
    pulse_start();
    send_byte(8'(n), 1'b0);
    send_byte(8'(n >> 8), 1'b0);
    chk({tag, "_error"}, 32'(error), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(core_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_hold", 32'(core_hold), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    reset = 1'b1;
    tick();

    // Basic and stalled two-word loads.
    img[0] = 16'h1234; img[1] = 16'h5678;
    run_load(2, 1'b0, "basic");
    run_load(2, 1'b1, "stall");

    // abort while idle is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort_done", 32'(done), 1);
    chk("idle_abort_error", 32'(error), 0);

    // Randomized images.
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img[i] = 16'($urandom);
      run_load(n, 1'($urandom_range(0, 1)), "rand");
    end

    bad_len(257, "len257");
    bad_len(0, "len0");

    // Abort mid-word after one complete write.
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h78, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_error", 32'(error), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_word_cnt", 32'(word_cnt), 1);
    tick(); tick();
    chk("abort_nwrites", 32'(obs_addr.size()), 1);
    if (obs_addr.size() > 0) chk("abort_w0", 32'(obs_data[0]), 32'h1234);

    // Abort coinciding with the completing byte of a word.
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h34, 1'b0);
    in_valid = 1'b1; in_data = 8'h12; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_same_wen", 32'(w_en), 0);
    chk("abort_same_error", 32'(error), 1);
    chk("abort_same_word_cnt", 32'(word_cnt), 0);
    tick();
    chk("abort_same_nwrites", 32'(obs_addr.size()), 0);

    // Full memory image.
    for (int i = 0; i < DEPTH; i++) img[i] = 16'(i);
    run_load(DEPTH, 1'b0, "full");
    if (obs_addr.size() == DEPTH) begin
      chk("full_last_addr", 32'(obs_addr[DEPTH-1]), 32'(DEPTH - 1));
      chk("full_last_data", 32'(obs_data[DEPTH-1]), 32'h00FF);
    end

    // Reset in the middle of a session.
    pulse_start();
    send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hDD;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    chk("mrst_w_en", 32'(w_en), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_hold", 32'(core_hold), 0);
    chk("mrst_word_cnt", 32'(word_cnt), 0);
    chk("mrst_w_addr", 32'(w_addr), 0);
    chk("mrst_w_data", 32'(w_data), 0);
    chk("mrst_ready", 32'(in_ready), 0);
    repeat (4) tick();
    chk("mrst_nwrites", 32'(obs_addr.size()), 1);
    img[0] = 16'hCAFE; img[1] = 16'hBEEF; img[2] = 16'h0F0F;
    run_load(3, 1'b1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the read-only instruction cache. Receives a byte stream carrying a program image, for example from a UART receiver or debug port.
- Assembles the bytes into 16-bit instruction words and drives the instruction-memory write port sequentially from address 0.
- Holds the core in reset (core_hold) for the whole load session.
- Image format: 16-bit little-endian word count N, then 2N bytes, each word little-endian.

Parameters:
DEPTH, 256, number of instruction words in memory; maximum legal N.
ADDR_W, 16, width of w_addr and word_cnt.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; begins a load session when idle
abort  in  1  terminates an active session
in_valid  in  1  in_data holds a byte
in_data  in  8  stream byte
in_ready  out  1  loader accepts a byte this cycle
w_en  out  1  instruction-memory write strobe
w_addr  out  ADDR_W  write word address
w_data  out  16  write word
core_hold  out  1  keeps the core in reset while loading
busy  out  1  session active
done  out  1  sticky: last session completed successfully
error  out  1  sticky: last session failed (bad length or abort)
word_cnt  out  ADDR_W  words written in current or last session

Behaviour:
- Reset (reset low at a rising edge):
  - state = IDLE.
  - All outputs 0: in_ready, w_en, w_addr, w_data, core_hold, busy, done, error, word_cnt.
  - Any partial word or length is discarded.
  - Reset mid-session is valid; no w_en occurs on the following cycles.
- A byte transfer occurs on an edge where in_valid & in_ready.
  - in_ready is 1 only in states LEN_LO, LEN_HI, DATA_LO, DATA_HI.
  - in_ready is combinational from state only; it never depends on in_valid.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, FINISH.
  - IDLE: on start -> LEN_LO. Same edge: done=0, error=0, word_cnt=0, core_hold=1, busy=1. A byte presented in the start cycle is not accepted.
  - LEN_LO: on transfer, latch len[7:0] -> LEN_HI.
  - LEN_HI: on transfer, len = {in_data, len_lo}.
    - If len==0 or len>DEPTH -> IDLE with error=1, core_hold=0, busy=0.
    - Otherwise -> DATA_LO.
  - DATA_LO: on transfer, latch lo byte -> DATA_HI.
  - DATA_HI: on transfer, at that edge:
    - w_en=1, w_addr=word_cnt, w_data={in_data, lo}, word_cnt=word_cnt+1.
    - If word_cnt+1==len -> FINISH, else -> DATA_LO.
  - FINISH: one cycle, then -> IDLE with done=1, core_hold=0, busy=0.
- w_en is registered. It is high for exactly one cycle per assembled word and 0 in every other cycle. w_addr/w_data hold their last values when w_en=0.
- Latency:
  - First write strobe appears the cycle after the 2nd byte of a word is accepted.
  - done rises two edges after the final byte is accepted, i.e. one cycle after the final w_en.
- Stalls: in_valid low for any number of cycles freezes state; no timeout.
- abort:
  - Sampled in LEN_LO..DATA_HI -> IDLE next edge with error=1, core_hold=0, busy=0.
  - A completed write on that same edge is suppressed: abort has priority over the transfer.
  - word_cnt keeps the count of words already written.
  - Ignored in IDLE and FINISH.
- start while busy is ignored.
- done and error are mutually exclusive. Both hold until the next accepted start or reset.
- Addresses never wrap: len ≤ DEPTH guarantees w_addr ≤ DEPTH-1.

Test Plan:
1. Basic load:
   - Stimulus: start, then stream 02 00 34 12 78 56 back-to-back.
   - Response: w_en pulses at addr 0 data 0x1234, then addr 1 data 0x5678. done=1 one cycle after the second write. word_cnt=2, core_hold=0, error=0. in_ready low in IDLE.
2. Stalled stream:
   - Stimulus: same bytes as scenario 1, in_valid toggled every other cycle with junk in_data while low.
   - Response: identical two writes, no extra w_en, done=1.
3. Bad length:
   - Stimulus 3a: length 01 01 (257).
   - Stimulus 3b: length 00 00.
   - Response for each: error=1, done=0, no w_en, returns IDLE, core_hold=0.
4. Abort mid-word:
   - Stimulus: len 02 00, bytes 34 12 78, then abort.
   - Response: single write 0x1234 at addr 0, error=1, word_cnt=1, no second write.
   - Variant: assert abort on the same edge as a DATA_HI transfer -> no write on that edge.
5. Full memory:
   - Stimulus: len 00 01 (256), words 0x0000..0x00FF.
   - Response: last write at addr 255 data 0x00FF, word_cnt=256, done=1.
6. Reset mid-session:
   - Stimulus: reset low for 1 cycle after 3 data bytes.
   - Response: all outputs 0 next edge, no further w_en. A subsequent start restarts cleanly at addr 0.
